// File: rtl/alu_rr_sequencer_pkg.sv
// alu_rr_sequencer_pkg: shared ALU function codes, flag bit indices, sequencer states and trap rule
package alu_rr_sequencer_pkg;
  localparam logic [3:0] FUN_ADD  = 4'b0000;
  localparam logic [3:0] FUN_SUB  = 4'b0001;
  localparam logic [3:0] FUN_MUL  = 4'b0010;
  localparam logic [3:0] FUN_DIV  = 4'b0011;
  localparam logic [3:0] FUN_AND  = 4'b0100;
  localparam logic [3:0] FUN_OR   = 4'b0101;
  localparam logic [3:0] FUN_NAND = 4'b0110;
  localparam logic [3:0] FUN_NOR  = 4'b0111;
  localparam logic [3:0] FUN_XOR  = 4'b1000;
  localparam logic [3:0] FUN_XNOR = 4'b1001;
  localparam logic [3:0] FUN_CMPE = 4'b1010;
  localparam logic [3:0] FUN_CMPG = 4'b1011;
  localparam logic [3:0] FUN_CMPL = 4'b1100;
  localparam logic [3:0] FUN_SHR  = 4'b1101;
  localparam logic [3:0] FUN_SHL  = 4'b1110;
  localparam logic [3:0] FUN_NOP  = 4'b1111;
  localparam int FLG_CARRY = 4;
  localparam int FLG_ARITH = 3;
  localparam int FLG_LOGIC = 2;
  localparam int FLG_CMP   = 1;
  localparam int FLG_SHIFT = 0;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  function automatic logic is_trap(input logic [3:0] fun, input logic b_zero);
    return fun == FUN_NOP || (fun == FUN_DIV && b_zero);
  endfunction
endpackage

// File: rtl/alu_rr_sequencer_rr_arb2.sv
// alu_rr_sequencer_rr_arb2: 2-way round-robin grant; last_grant advances only when en and a grant is taken
// ports: clk, rst (sync, high), en (grant may be taken), valid0/1 in, grant0/1 out (combinational on valid)
module alu_rr_sequencer_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);
  logic last_grant;
  assign grant0 = valid0 & (~valid1 | last_grant);
  assign grant1 = valid1 & (~valid0 | ~last_grant);
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (en & (grant0 | grant1)) last_grant <= grant1;
  end
endmodule

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: shares one registered ALU between two round-robin requesters, one shared response port
// ports: CLK, RST (sync, high); req0_*/req1_* valid/ready request ports with a, b, fun;
//        rsp_* valid/ready response with id, data, flags, err; alu_a/alu_b/alu_fun to the ALU, alu_out/alu_flags back
module alu_rr_sequencer
  import alu_rr_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FUN_W = 4,
  parameter logic [DATA_W-1:0] ERR_RES = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUN_W-1:0]  req0_fun,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUN_W-1:0]  req1_fun,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_flags,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags
);
  state_t state;
  logic [DATA_W-1:0] op_a, op_b, in_a, in_b;
  logic [FUN_W-1:0] op_fun, in_fun;
  logic op_id, grant0, grant1, idle, acc, sel, trap, busy;
  assign idle = state == IDLE;
  alu_rr_sequencer_rr_arb2 u_arb (
    .clk(CLK), .rst(RST), .en(idle),
    .valid0(req0_valid), .valid1(req1_valid),
    .grant0(grant0), .grant1(grant1)
  );
  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;
  assign acc = req0_ready | req1_ready;
  assign sel = req1_ready;
  assign in_a = sel ? req1_a : req0_a;
  assign in_b = sel ? req1_b : req0_b;
  assign in_fun = sel ? req1_fun : req0_fun;
  assign trap = is_trap(in_fun, in_b == '0);
  // the ALU sees the operation only while it computes (EXEC) and while its result is captured (CAPT)
  assign busy = state == EXEC || state == CAPT;
  assign alu_a = busy ? op_a : '0;
  assign alu_b = busy ? op_b : '0;
  assign alu_fun = busy ? op_fun : FUN_W'(FUN_NOP);
  assign rsp_id = op_id;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      op_fun <= FUN_W'(FUN_NOP);
      op_id <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          op_a <= in_a;
          op_b <= in_b;
          op_fun <= in_fun;
          op_id <= sel;
          state <= trap ? RESP : EXEC;
          if (trap) begin
            rsp_valid <= 1'b1;
            rsp_data <= ERR_RES;
            rsp_flags <= '0;
            rsp_err <= 1'b1;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_data <= alu_out;
          rsp_flags <= alu_flags;
          rsp_err <= 1'b0;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb_alu_rr_sequencer: transaction-level model of the sequencer driving a behavioural registered ALU
module tb_alu_rr_sequencer;
  import alu_rr_sequencer_pkg::*;
  localparam logic [15:0] ERR = 16'hBAD0;
  logic CLK = 1'b0, RST = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_fun = 0, req1_fun = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [15:0] rsp_data, alu_a, alu_b, alu_out;
  logic [4:0] rsp_flags, alu_flags;
  logic [3:0] alu_fun;
  always #5 CLK = ~CLK;
  alu_rr_sequencer #(.DATA_W(16), .FUN_W(4), .ERR_RES(ERR)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out), .alu_flags(alu_flags)
  );
  function automatic logic [15:0] alu_res(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    case (f)
      FUN_ADD:  return a + b;
      FUN_SUB:  return a - b;
      FUN_MUL:  return a * b;
      FUN_DIV:  return b == 0 ? 16'h0 : a / b;
      FUN_AND:  return a & b;
      FUN_OR:   return a | b;
      FUN_NAND: return ~(a & b);
      FUN_NOR:  return ~(a | b);
      FUN_XOR:  return a ^ b;
      FUN_XNOR: return ~(a ^ b);
      FUN_CMPE: return a == b ? 16'd1 : 16'd0;
      FUN_CMPG: return a > b ? 16'd2 : 16'd0;
      FUN_CMPL: return a < b ? 16'd3 : 16'd0;
      FUN_SHR:  return a >> 1;
      FUN_SHL:  return a << 1;
      default:  return 16'h0;
    endcase
  endfunction
  function automatic logic [4:0] alu_flg(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic [4:0] r;
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    r[FLG_CARRY] = f == FUN_ADD ? s[16] : f == FUN_SUB ? a >= b : 1'b0;
    r[FLG_ARITH] = f <= FUN_DIV;
    r[FLG_LOGIC] = f >= FUN_AND && f <= FUN_XNOR;
    r[FLG_CMP] = f >= FUN_CMPE && f <= FUN_CMPL;
    r[FLG_SHIFT] = f == FUN_SHR || f == FUN_SHL;
    return r;
  endfunction
  always @(posedge CLK) alu_out <= alu_res(alu_a, alu_b, alu_fun);
  assign alu_flags = alu_flg(alu_a, alu_b, alu_fun);
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  bit rq_v[2];
  logic [15:0] rq_a[2], rq_b[2];
  logic [3:0] rq_f[2];
  bit pend = 0, m_last = 1, e_err = 0, e_id = 0, after_rst = 0;
  logic [15:0] e_a = 0, e_b = 0, e_data = 0;
  logic [3:0] e_fun = 0;
  logic [4:0] e_flags = 0;
  int n = 0, n0 = 0, due = 0, mode = 0;
  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    rq_v[i] = 1;
    rq_a[i] = a;
    rq_b[i] = b;
    rq_f[i] = f;
  endtask
  task automatic new_req(input int i);
    rq_v[i] = $urandom_range(3) != 0;
    rq_a[i] = 16'($urandom);
    rq_b[i] = $urandom_range(3) == 0 ? 16'h0 : 16'($urandom);
    rq_f[i] = 4'($urandom);
  endtask
  task automatic step(input bit r, input bit rdy);
    bit g0, g1, rv, on;
    int s;
    @(negedge CLK);
    RST = r;
    rsp_ready = rdy;
    req0_valid = rq_v[0]; req0_a = rq_a[0]; req0_b = rq_b[0]; req0_fun = rq_f[0];
    req1_valid = rq_v[1]; req1_a = rq_a[1]; req1_b = rq_b[1]; req1_fun = rq_f[1];
    #1;
    g0 = !pend && rq_v[0] && (!rq_v[1] || m_last);
    g1 = !pend && rq_v[1] && (!rq_v[0] || !m_last);
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    rv = pend && n >= due;
    chk("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("rsp_data", 32'(rsp_data), 32'(e_data));
      chk("rsp_flags", 32'(rsp_flags), 32'(e_flags));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
    end
    if (after_rst) begin
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_flags", 32'(rsp_flags), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
    end
    on = pend && !e_err && n <= n0 + 1;
    chk("alu_fun", 32'(alu_fun), 32'(on ? e_fun : FUN_NOP));
    chk("alu_a", 32'(alu_a), 32'(on ? e_a : 16'h0));
    chk("alu_b", 32'(alu_b), 32'(on ? e_b : 16'h0));
    @(posedge CLK);
    n++;
    after_rst = r;
    if (r) begin
      pend = 0;
      m_last = 1;
    end else if (rv && rdy) pend = 0;
    else if (g0 || g1) begin
      s = g1 ? 1 : 0;
      e_id = g1;
      e_a = rq_a[s];
      e_b = rq_b[s];
      e_fun = rq_f[s];
      e_err = e_fun == FUN_NOP || (e_fun == FUN_DIV && e_b == 0);
      e_data = e_err ? ERR : alu_res(e_a, e_b, e_fun);
      e_flags = e_err ? 5'd0 : alu_flg(e_a, e_b, e_fun);
      pend = 1;
      n0 = n;
      due = n + (e_err ? 0 : 2);
      m_last = g1;
      if (mode == 0) rq_v[s] = 0;
      else if (mode == 2) new_req(s);
    end
    if (mode == 2) for (int i = 0; i < 2; i++) if (!rq_v[i] && $urandom_range(3) == 0) new_req(i);
  endtask
  task automatic run(input int k, input int rdy_pct);
    for (int i = 0; i < k; i++) step(1'b0, $urandom_range(99) < rdy_pct);
  endtask
  initial begin
    rq_v[0] = 0; rq_v[1] = 0;
    for (int i = 0; i < 2; i++) begin rq_a[i] = 0; rq_b[i] = 0; rq_f[i] = 0; end
    repeat (2) @(posedge CLK);
    step(1'b1, 1'b0);
    run(2, 100);
    set_req(0, 16'hFFFF, 16'h0001, FUN_ADD);
    run(6, 100);
    step(1'b1, 1'b1);
    mode = 1;
    set_req(0, 16'hF0F0, 16'h0FF0, FUN_XOR);
    set_req(1, 16'h0005, 16'h0003, FUN_SUB);
    run(18, 100);
    mode = 0;
    rq_v[0] = 0; rq_v[1] = 0;
    run(5, 100);
    set_req(1, 16'h0010, 16'h0000, FUN_DIV);
    run(5, 100);
    mode = 1;
    set_req(0, 16'h0009, 16'h0004, FUN_CMPG);
    run(8, 0);
    mode = 0;
    rq_v[0] = 0;
    run(4, 100);
    set_req(0, 16'h1234, 16'h0000, FUN_SHL);
    for (int i = 0; i < 10 && !(pend && e_fun == FUN_SHL && n == n0 + 1); i++) run(1, 100);
    chk("reach_capt", 32'(pend && e_fun == FUN_SHL && n == n0 + 1), 32'd1);
    set_req(1, 16'h0001, 16'h0002, FUN_ADD);
    step(1'b1, 1'b1);
    run(8, 100);
    set_req(0, 16'h8001, 16'h0001, FUN_SHR);
    run(6, 100);
    set_req(0, 16'h0100, 16'h0100, FUN_MUL);
    run(6, 100);
    mode = 2;
    new_req(0);
    new_req(1);
    for (int i = 0; i < 800; i++) step($urandom_range(199) == 0, $urandom_range(99) < 70);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
